sample_pacer: RTL and testbench



---
 rtl/sample_pacer.sv | 126 ++++++++++++
 tb/tb_sample_pacer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_pacer.sv
// Transmit-side sample pacer. Bursty 16-bit samples are buffered in a small FIFO.
// They are replayed one per slot on a fixed grid of TICK_DIV clocks. An empty
// FIFO on a slot produces a gap slot with valid_out low. Sustained starvation
// returns the block to PRIME so it can refill before output resumes.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_PRIME | filling; no reads; tick/valid/running held low
//   ST_RUN   | one slot serviced every TICK_DIV clocks (pop or gap)
module sample_pacer #(
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 4,
  parameter int PRIME    = 2,
  parameter int MAX_MISS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              sample_in,
  input  logic                     valid_in,
  output logic                     ready_in,
  output logic [15:0]              sample_out,
  output logic                     valid_out,
  output logic                     tick_out,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [15:0]              underrun_count,
  output logic                     running
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TICK_DIV);

  typedef enum logic {ST_PRIME, ST_RUN} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q;
  logic [AW:0]     fill_q;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [2:0]      miss_q;
  logic [15:0]     mem [DEPTH];

  logic slot, push, pop, service, gap, miss_limit;

  assign slot       = (tick_q == TW'(TICK_DIV - 1));
  assign ready_in   = (fill_q != (AW+1)'(DEPTH));
  assign push       = valid_in && ready_in;
  assign fill_level = fill_q;
  assign running    = (state_q == ST_RUN);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_PRIME;
    else       state_q <= state_d;
  end

  // Slot decision: the priming slot is serviced in the same cycle it leaves PRIME.
  always_comb begin
    state_d    = state_q;
    service    = 1'b0;
    pop        = 1'b0;
    gap        = 1'b0;
    miss_limit = 1'b0;
    case (state_q)
      ST_PRIME: begin
        if (slot && (fill_q >= (AW+1)'(PRIME))) begin
          state_d = ST_RUN;
          service = 1'b1;
          pop     = 1'b1;
        end
      end
      ST_RUN: begin
        if (slot) begin
          service = 1'b1;
          if (fill_q != '0) begin
            pop = 1'b1;
          end else begin
            gap = 1'b1;
            if (miss_q == 3'(MAX_MISS - 1)) begin
              miss_limit = 1'b1;
              state_d    = ST_PRIME;
            end
          end
        end
      end
      default: state_d = ST_PRIME;
    endcase
  end

  // Free-running slot divider, pointers, occupancy, slot outputs and miss tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q         <= '0;
      fill_q         <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      miss_q         <= '0;
      sample_out     <= '0;
      valid_out      <= 1'b0;
      tick_out       <= 1'b0;
      underrun_count <= '0;
    end else begin
      tick_q    <= slot ? '0 : tick_q + 1'b1;
      tick_out  <= service;
      valid_out <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        sample_out <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
      if (gap && (underrun_count != 16'hFFFF)) underrun_count <= underrun_count + 16'd1;
      if (pop)             miss_q <= '0;
      else if (miss_limit) miss_q <= '0;
      else if (gap)        miss_q <= miss_q + 3'd1;
    end
  end

  // Sample storage; a pop reads the pre-write contents, so there is no same-cycle bypass.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_in;
  end

endmodule

// File: tb/tb_sample_pacer.sv
// Bench for sample_pacer: directed scenarios plus random bursts, checked every
// cycle against a queue-based model of the slot rules.
module tb_sample_pacer;

  localparam int DEPTH    = 8;
  localparam int TICK_DIV = 4;
  localparam int PRIME    = 2;
  localparam int MAX_MISS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in = '0;
  logic        valid_in = 1'b0;

  logic        ready_in, valid_out, tick_out, running;
  logic [15:0] sample_out, underrun_count;
  logic [3:0]  fill_level;

  logic        f_ready, f_valid, f_tick, f_running;
  logic [15:0] f_sample, f_under;
  logic [3:0]  f_fill;

  sample_pacer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .PRIME(PRIME), .MAX_MISS(MAX_MISS)) u_dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .valid_in(valid_in),
    .ready_in(ready_in), .sample_out(sample_out), .valid_out(valid_out),
    .tick_out(tick_out), .fill_level(fill_level), .underrun_count(underrun_count),
    .running(running)
  );

  // Second instance that cannot leave PRIME before it fills, for the full-FIFO case.
  sample_pacer #(.DEPTH(8), .TICK_DIV(16), .PRIME(8), .MAX_MISS(4)) u_full (
    .clk(clk), .reset(reset), .sample_in(sample_in), .valid_in(valid_in),
    .ready_in(f_ready), .sample_out(f_sample), .valid_out(f_valid),
    .tick_out(f_tick), .fill_level(f_fill), .underrun_count(f_under),
    .running(f_running)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] q[$];
  int          phase;
  bit          run_flag;
  int          miss;
  int unsigned m_under;
  bit          m_tick, m_valid;
  logic [15:0] m_sample;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("fill_level", 32'(fill_level), 32'(q.size()));
    chk("ready_in", 32'(ready_in), 32'(q.size() != DEPTH));
    chk("tick_out", 32'(tick_out), 32'(m_tick));
    chk("valid_out", 32'(valid_out), 32'(m_valid));
    chk("sample_out", 32'(sample_out), 32'(m_sample));
    chk("underrun_count", 32'(underrun_count), m_under);
    chk("running", 32'(running), 32'(run_flag));
  endtask

  task automatic model_reset();
    q.delete();
    phase    = 0;
    run_flag = 0;
    miss     = 0;
    m_under  = 0;
    m_tick   = 0;
    m_valid  = 0;
    m_sample = '0;
  endtask

  // One clock: drive inputs, advance the model through the slot rules, then compare.
  task automatic cycle(input bit v, input logic [15:0] d);
    int fill;
    bit wr, slot, serve;
    valid_in  = v;
    sample_in = d;
    fill  = q.size();
    wr    = v && (fill != DEPTH);
    slot  = (phase == TICK_DIV - 1);
    serve = slot && (run_flag || fill >= PRIME);
    m_tick  = serve;
    m_valid = 0;
    if (serve) begin
      run_flag = 1;
      if (fill > 0) begin
        m_sample = q.pop_front();
        m_valid  = 1;
        miss     = 0;
      end else begin
        if (m_under != 32'hFFFF) m_under++;
        miss++;
        if (miss == MAX_MISS) begin
          run_flag = 0;
          miss     = 0;
        end
      end
    end
    if (wr) q.push_back(d);
    phase = (phase + 1) % TICK_DIV;
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic apply_reset();
    #2;
    reset = 1'b1;
    valid_in = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("f_fill_rst", 32'(f_fill), 32'd0);
    chk("f_ready_rst", 32'(f_ready), 32'd1);
    chk("f_sample_rst", 32'(f_sample), 32'd0);
    chk("f_under_rst", 32'(f_under), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0);
  endtask

  // Advance until the model is running with 'want' samples on a slot cycle.
  task automatic seek(input int want, output bit found);
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (run_flag && q.size() == want && phase == TICK_DIV - 1) begin
        found = 1;
        return;
      end
      cycle(1'b0, 16'h0);
    end
  endtask

  initial begin
    bit found;
    int p;
    model_reset();
    apply_reset();

    // Three back-to-back writes, then starvation
    idle(2);
    cycle(1'b1, 16'h0010);
    cycle(1'b1, 16'h0020);
    cycle(1'b1, 16'h0030);
    idle(40);
    chk("t1_under", 32'(underrun_count), 32'd4);
    chk("t1_running", 32'(running), 32'd0);

    // Two samples then sustained starvation
    apply_reset();
    cycle(1'b1, 16'h1111);
    cycle(1'b1, 16'h2222);
    idle(40);
    chk("t2_under", 32'(underrun_count), 32'd4);
    chk("t2_running", 32'(running), 32'd0);
    chk("t2_tick", 32'(tick_out), 32'd0);

    // Full FIFO held in PRIME
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 16'(16'h0100 + i));
      chk("t3_f_fill", 32'(f_fill), 32'((i + 1) < 8 ? (i + 1) : 8));
      chk("t3_f_ready", 32'(f_ready), 32'((i + 1) < 8));
      chk("t3_f_tick", 32'(f_tick), 32'd0);
      chk("t3_f_valid", 32'(f_valid), 32'd0);
      chk("t3_f_running", 32'(f_running), 32'd0);
    end

    // Simultaneous write and pop with one sample queued
    apply_reset();
    cycle(1'b1, 16'h0A0A);
    cycle(1'b1, 16'h0B0B);
    seek(1, found);
    chk("t4_reach", 32'(found), 32'd1);
    cycle(1'b1, 16'h7FFF);
    chk("t4_fill", 32'(fill_level), 32'd1);
    chk("t4_pop", 32'(sample_out), 32'h0B0B);
    idle(TICK_DIV);
    chk("t4_next", 32'(sample_out), 32'h7FFF);
    chk("t4_next_valid", 32'(valid_out), 32'd1);

    // Write into empty FIFO on a slot cycle
    seek(0, found);
    chk("t5_reach", 32'(found), 32'd1);
    cycle(1'b1, 16'h8000);
    chk("t5_gap_valid", 32'(valid_out), 32'd0);
    chk("t5_gap_tick", 32'(tick_out), 32'd1);
    idle(TICK_DIV);
    chk("t5_next", 32'(sample_out), 32'h8000);
    chk("t5_next_valid", 32'(valid_out), 32'd1);

    // Random bursts with varying producer duty
    apply_reset();
    for (int w = 0; w < 16; w++) begin
      p = $urandom_range(0, 100);
      for (int i = 0; i < 40; i++)
        cycle($urandom_range(0, 99) < p, 16'($urandom));
    end

    // Async reset mid-stream with five samples queued
    apply_reset();
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 5) begin
        found = 1;
        break;
      end
      cycle(1'b1, 16'(16'hC000 + i));
    end
    chk("t6_reach", 32'(found), 32'd1);
    apply_reset();
    chk("t6_fill", 32'(fill_level), 32'd0);
    chk("t6_ready", 32'(ready_in), 32'd1);
    chk("t6_running", 32'(running), 32'd0);
    idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
